ysyx_220066_mem_responder: RTL and testbench
============================================

Name: ysyx_220066_mem_responder

Overview:
Memory-side responder for the CPU top's three request channels: instruction refill, data read, data write. It services cache-line bursts (512-bit, 8 beats) and single uncached accesses. All traffic goes to one 64-bit single-port backing SRAM with 1-cycle read latency. It arbitrates between channels, checks address range and size, and returns ready/err pulses with line or word data.

Parameters:
MEM_BASE, 64'h8000_0000, byte base address of backing memory
MEM_AW, 20, log2 of backing memory size in 64-bit words

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ins_req  in  1  instruction request, held until ins_ready
ins_burst  in  1  1 = 64-byte line read, 0 = single 64-bit word read
ins_addr  in  64  byte address (line-aligned when burst)
ins_ready  out  1  one-cycle completion pulse
ins_err  out  1  error flag, valid only with ins_ready
ins_data  out  512  line data; beat k in [64k+63:64k]; single read in [63:0], upper bits zero
rd_req  in  1  data read request
rd_burst  in  1  line/single select
rd_len  in  3  single-access size: 0=1B, 1=2B, 2=4B, 3=8B; 4..7 illegal
rd_addr  in  64  byte address
rd_ready  out  1  completion pulse
rd_err  out  1  error flag with rd_ready
rd_data  out  512  same layout as ins_data
wr_req  in  1  data write request
wr_burst  in  1  line/single select
wr_len  in  3  single-access size, same encoding as rd_len
wr_mask  in  8  byte strobes for a single write; ignored for burst
wr_addr  in  64  byte address
wr_data  in  512  line data, or word in [63:0]
wr_ready  out  1  completion pulse
wr_err  out  1  error flag with wr_ready
mem_en  out  1  SRAM access enable
mem_we  out  1  SRAM write
mem_addr  out  MEM_AW  SRAM word index
mem_wstrb  out  8  SRAM byte strobes
mem_wdata  out  64  SRAM write data
mem_rdata  in  64  SRAM read data, valid the cycle after mem_en & !mem_we

Behaviour:
- Interface decisions: single clock clk; reset rst is synchronous and active-high.
- Reset: state IDLE. All ready/err pulses and mem_en/mem_we are 0. ins_data and rd_data are 0. Beat counter is 0. A reset mid-transaction aborts it, no response is given, and the requester must re-request.
- Requester rule: req and its qualifiers stay stable while req is high. req drops no later than the cycle after ready.
- Arbitration in IDLE uses fixed priority: wr_req > rd_req > ins_req. A simultaneous write and read are served write first, so writeback precedes refill. Losers keep waiting.
- FSM states: IDLE, RBEAT, RLAST, WBEAT, RESP.
- Accept at cycle T: latch channel, burst, word address (addr minus MEM_BASE, bits [MEM_AW+2:3]), and size/mask.
- Error check at accept:
  - address outside [MEM_BASE, MEM_BASE + 8*2^MEM_AW);
  - burst with addr[5:0] != 0;
  - single access with len > 3;
  - single access misaligned for its size.
- On error: go to RESP with err=1. No SRAM access. ready+err is asserted at T+1.
- Burst read:
  - RBEAT issues mem_en for beats 0..7 at T+1..T+8, word index = base + k.
  - mem_rdata is captured into the data buffer slot k one cycle later (T+2..T+9). RLAST covers the final capture.
  - ready is at T+10.
- Single read: issue at T+1, capture at T+2, ready at T+3. Upper 448 bits are 0.
- Burst write: mem_we with wstrb 8'hFF for beats 0..7 at T+1..T+8; ready at T+9.
- Single write: one beat at T+1 with wstrb = wr_mask; ready at T+2. A mask of 0 still completes with no byte changed.
- RESP: asserts exactly one cycle of ready on the owning channel only, with err as computed. Then returns to IDLE. The earliest next accept is the cycle after the ready pulse.
- ins_data/rd_data are updated only by their own channel's reads and hold their value between responses. Errors leave data unchanged.
- The beat counter is 3 bits. Word index arithmetic wraps modulo 2^MEM_AW; it cannot overflow because of the range check.

Test Plan:
- Preload words 0..7 with 64'h1111*(k+1). ins_req, burst, addr 0x8000_0000 at T -> ins_ready at T+10, ins_err=0, ins_data[64k+63:64k] = preload k.
- rd_req single, len=3, addr 0x8000_0008 -> rd_ready at T+3, rd_data[63:0] = 64'h2222, rd_data[511:64] = 0.
- wr_req single, addr 0x8000_0010, mask 8'h0F, data 64'hFFFF_FFFF_FFFF_FFFF over word 64'h3333 -> wr_ready at T+2; read-back = 64'h0000_0000_FFFF_FFFF.
- wr_req and ins_req asserted in the same cycle -> 8 write beats first, wr_ready at T+9. ins accepted at T+10, ins_ready at T+20, and ins_data reflects the new line.
- rd_req addr 0x1000_0000, and separately a burst with addr 0x8000_0004 -> rd_ready+rd_err at T+1, mem_en never asserted, rd_data unchanged.
- Assert rst at T+4 of a burst read -> all outputs 0 at T+5. Re-issue -> normal response 10 cycles after accept.

Source files
------------

// File: rtl/ysyx_220066_mem_responder.sv
// Memory-side responder: arbitrates instruction refill, data read and data write
// channels onto one 64-bit single-port SRAM, with 8-beat line bursts or single words.
module ysyx_220066_mem_responder #(
    parameter logic [63:0] MEM_BASE = 64'h8000_0000,
    parameter int          MEM_AW   = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ins_req,
    input  logic              ins_burst,
    input  logic [63:0]       ins_addr,
    output logic              ins_ready,
    output logic              ins_err,
    output logic [511:0]      ins_data,
    input  logic              rd_req,
    input  logic              rd_burst,
    input  logic [2:0]        rd_len,
    input  logic [63:0]       rd_addr,
    output logic              rd_ready,
    output logic              rd_err,
    output logic [511:0]      rd_data,
    input  logic              wr_req,
    input  logic              wr_burst,
    input  logic [2:0]        wr_len,
    input  logic [7:0]        wr_mask,
    input  logic [63:0]       wr_addr,
    input  logic [511:0]      wr_data,
    output logic              wr_ready,
    output logic              wr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wstrb,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata
);

    typedef enum logic [2:0] {IDLE, RBEAT, RLAST, WBEAT, RESP} state_t;
    typedef enum logic [1:0] {CH_INS, CH_RD, CH_WR} chan_t;

    localparam logic [MEM_AW-1:0] ADDR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

    state_t      state;
    chan_t       chan;
    logic        burst;
    logic [2:0]  beat;
    logic        rd_pend;
    logic [2:0]  rd_slot;

    logic        sel_req;
    chan_t       sel_chan;
    logic        sel_burst;
    logic [2:0]  sel_len;
    logic [63:0] sel_addr;
    logic [63:0] off;
    logic        range_bad;
    logic        align_bad;
    logic        acc_err;

    // Fixed priority so a dirty-line writeback always lands before its refill.
    always_comb begin
        sel_req   = 1'b1;
        sel_chan  = CH_INS;
        sel_burst = ins_burst;
        sel_len   = 3'd3;
        sel_addr  = ins_addr;
        if (wr_req) begin
            sel_chan  = CH_WR;
            sel_burst = wr_burst;
            sel_len   = wr_len;
            sel_addr  = wr_addr;
        end else if (rd_req) begin
            sel_chan  = CH_RD;
            sel_burst = rd_burst;
            sel_len   = rd_len;
            sel_addr  = rd_addr;
        end else if (!ins_req) begin
            sel_req = 1'b0;
        end
    end

    always_comb begin
        off       = sel_addr - MEM_BASE;
        range_bad = (sel_addr < MEM_BASE) || (off[63:MEM_AW+3] != '0);
        case (sel_len[1:0])
            2'd0:    align_bad = 1'b0;
            2'd1:    align_bad = off[0];
            2'd2:    align_bad = |off[1:0];
            default: align_bad = |off[2:0];
        endcase
        acc_err = range_bad || (sel_burst ? (|off[5:0]) : (sel_len[2] || align_bad));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            chan      <= CH_INS;
            burst     <= 1'b0;
            beat      <= 3'd0;
            rd_pend   <= 1'b0;
            rd_slot   <= 3'd0;
            ins_ready <= 1'b0;
            ins_err   <= 1'b0;
            ins_data  <= '0;
            rd_ready  <= 1'b0;
            rd_err    <= 1'b0;
            rd_data   <= '0;
            wr_ready  <= 1'b0;
            wr_err    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= 8'h00;
            mem_wdata <= 64'h0;
        end else begin
            // Read data returns one cycle after issue; land it in the owner's buffer.
            rd_pend <= 1'b0;
            if (rd_pend) begin
                if (chan == CH_INS) begin
                    if (burst) ins_data[{rd_slot, 6'd0} +: 64] <= mem_rdata;
                    else       ins_data <= {448'h0, mem_rdata};
                end else begin
                    if (burst) rd_data[{rd_slot, 6'd0} +: 64] <= mem_rdata;
                    else       rd_data <= {448'h0, mem_rdata};
                end
            end

            case (state)
                IDLE: begin
                    if (sel_req) begin
                        chan     <= sel_chan;
                        burst    <= sel_burst;
                        beat     <= 3'd0;
                        mem_addr <= off[MEM_AW+2:3];
                        if (acc_err) begin
                            ins_ready <= (sel_chan == CH_INS);
                            ins_err   <= (sel_chan == CH_INS);
                            rd_ready  <= (sel_chan == CH_RD);
                            rd_err    <= (sel_chan == CH_RD);
                            wr_ready  <= (sel_chan == CH_WR);
                            wr_err    <= (sel_chan == CH_WR);
                            state     <= RESP;
                        end else if (sel_chan == CH_WR) begin
                            mem_en    <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_wstrb <= sel_burst ? 8'hFF : wr_mask;
                            mem_wdata <= wr_data[63:0];
                            state     <= WBEAT;
                        end else begin
                            mem_en    <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_wstrb <= 8'h00;
                            state     <= RBEAT;
                        end
                    end
                end
                RBEAT: begin
                    rd_pend <= 1'b1;
                    rd_slot <= beat;
                    if (!burst || beat == 3'd7) begin
                        mem_en <= 1'b0;
                        state  <= RLAST;
                    end else begin
                        beat     <= beat + 3'd1;
                        mem_addr <= mem_addr + ADDR_ONE;
                    end
                end
                RLAST: begin
                    ins_ready <= (chan == CH_INS);
                    rd_ready  <= (chan == CH_RD);
                    state     <= RESP;
                end
                WBEAT: begin
                    if (!burst || beat == 3'd7) begin
                        mem_en   <= 1'b0;
                        mem_we   <= 1'b0;
                        wr_ready <= 1'b1;
                        state    <= RESP;
                    end else begin
                        beat      <= beat + 3'd1;
                        mem_addr  <= mem_addr + ADDR_ONE;
                        mem_wdata <= wr_data[{beat + 3'd1, 6'd0} +: 64];
                    end
                end
                default: begin
                    ins_ready <= 1'b0;
                    ins_err   <= 1'b0;
                    rd_ready  <= 1'b0;
                    rd_err    <= 1'b0;
                    wr_ready  <= 1'b0;
                    wr_err    <= 1'b0;
                    beat      <= 3'd0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_220066_mem_responder.sv
// Directed bench for ysyx_220066_mem_responder with a small behavioural SRAM.
module tb_ysyx_220066_mem_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         ins_req, ins_burst;
    logic [63:0]  ins_addr;
    logic         ins_ready, ins_err;
    logic [511:0] ins_data;
    logic         rd_req, rd_burst;
    logic [2:0]   rd_len;
    logic [63:0]  rd_addr;
    logic         rd_ready, rd_err;
    logic [511:0] rd_data;
    logic         wr_req, wr_burst;
    logic [2:0]   wr_len;
    logic [7:0]   wr_mask;
    logic [63:0]  wr_addr;
    logic [511:0] wr_data;
    logic         wr_ready, wr_err;
    logic         mem_en, mem_we;
    logic [19:0]  mem_addr;
    logic [7:0]   mem_wstrb;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata;

    ysyx_220066_mem_responder dut (
        .clk(clk), .rst(rst),
        .ins_req(ins_req), .ins_burst(ins_burst), .ins_addr(ins_addr),
        .ins_ready(ins_ready), .ins_err(ins_err), .ins_data(ins_data),
        .rd_req(rd_req), .rd_burst(rd_burst), .rd_len(rd_len), .rd_addr(rd_addr),
        .rd_ready(rd_ready), .rd_err(rd_err), .rd_data(rd_data),
        .wr_req(wr_req), .wr_burst(wr_burst), .wr_len(wr_len), .wr_mask(wr_mask),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .wr_err(wr_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [63:0] sram [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_a;
    logic [63:0] pre_d;
    int          cyc = 0;
    int          en_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_we) sram[pre_a] <= pre_d;
        if (mem_en) begin
            en_cnt <= en_cnt + 1;
            if (mem_we) begin
                for (int b = 0; b < 8; b++)
                    if (mem_wstrb[b]) sram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr[9:0]];
            end
        end
    end

    int total = 0;
    int bad = 0;
    int t0, lat, en0;
    logic [511:0] exp_line, wline, rd_keep;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ch: 0=ins 1=rd 2=wr; lat is cycles since t0, -1 on timeout
    task automatic wait_rdy(input int ch, input int limit, output int l);
        l = -1;
        for (int i = 0; i < limit; i++) begin
            step();
            if ((ch == 0 && ins_ready) || (ch == 1 && rd_ready) || (ch == 2 && wr_ready)) begin
                l = cyc - t0;
                break;
            end
        end
    endtask

    task automatic do_rd(input logic burst, input logic [2:0] len, input logic [63:0] a, output int l);
        rd_req = 1'b1; rd_burst = burst; rd_len = len; rd_addr = a;
        t0 = cyc;
        wait_rdy(1, 30, l);
        rd_req = 1'b0;
    endtask

    task automatic do_wr(input logic [2:0] len, input logic [7:0] m, input logic [63:0] a, input logic [63:0] d, output int l);
        wr_req = 1'b1; wr_burst = 1'b0; wr_len = len; wr_mask = m; wr_addr = a; wr_data = {448'h0, d};
        t0 = cyc;
        wait_rdy(2, 30, l);
        wr_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ins_req = 0; ins_burst = 0; ins_addr = 0;
        rd_req = 0; rd_burst = 0; rd_len = 0; rd_addr = 0;
        wr_req = 0; wr_burst = 0; wr_len = 0; wr_mask = 0; wr_addr = 0; wr_data = 0;
        repeat (3) step();
        chk("rst_ready", {509'h0, ins_ready, rd_ready, wr_ready}, 512'h0);
        chk("rst_err", {509'h0, ins_err, rd_err, wr_err}, 512'h0);
        chk("rst_mem", {510'h0, mem_en, mem_we}, 512'h0);
        chk("rst_ins_data", ins_data, 512'h0);
        chk("rst_rd_data", rd_data, 512'h0);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            pre_we = 1'b1; pre_a = 10'(k); pre_d = 64'h1111 * 64'(k + 1);
            step();
        end
        pre_we = 1'b0;
        step();

        // line refill
        for (int k = 0; k < 8; k++) exp_line[64*k +: 64] = 64'h1111 * 64'(k + 1);
        ins_req = 1'b1; ins_burst = 1'b1; ins_addr = 64'h8000_0000;
        t0 = cyc;
        wait_rdy(0, 30, lat);
        ins_req = 1'b0;
        chk("ins_burst_lat", 512'(lat), 512'd10);
        chk("ins_burst_err", {511'h0, ins_err}, 512'h0);
        chk("ins_burst_data", ins_data, exp_line);
        step();

        do_rd(1'b0, 3'd3, 64'h8000_0008, lat);
        chk("rd_single_lat", 512'(lat), 512'd3);
        chk("rd_single_err", {511'h0, rd_err}, 512'h0);
        chk("rd_single_data", rd_data, {448'h0, 64'h2222});
        step();

        do_wr(3'd3, 8'h0F, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, lat);
        chk("wr_single_lat", 512'(lat), 512'd2);
        chk("wr_single_err", {511'h0, wr_err}, 512'h0);
        step();
        do_rd(1'b0, 3'd3, 64'h8000_0010, lat);
        chk("wr_readback", rd_data, {448'h0, 64'h0000_0000_FFFF_FFFF});
        step();

        do_wr(3'd3, 8'h00, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, lat);
        chk("wr_mask0_lat", 512'(lat), 512'd2);
        step();
        do_rd(1'b0, 3'd3, 64'h8000_0008, lat);
        chk("wr_mask0_keep", rd_data, {448'h0, 64'h2222});
        step();

        // write line and refill of the same line arrive together
        for (int k = 0; k < 8; k++) wline[64*k +: 64] = 64'hDEAD_0000 + 64'(k);
        wr_req = 1'b1; wr_burst = 1'b1; wr_len = 3'd3; wr_mask = 8'h00;
        wr_addr = 64'h8000_0040; wr_data = wline;
        ins_req = 1'b1; ins_burst = 1'b1; ins_addr = 64'h8000_0040;
        t0 = cyc;
        wait_rdy(2, 30, lat);
        wr_req = 1'b0;
        chk("wr_burst_lat", 512'(lat), 512'd9);
        chk("wr_first_ins_idle", {511'h0, ins_ready}, 512'h0);
        wait_rdy(0, 30, lat);
        ins_req = 1'b0;
        chk("ins_after_wr_lat", 512'(lat), 512'd20);
        chk("ins_after_wr_data", ins_data, wline);
        step();

        // error cases: ready+err next cycle, no SRAM access, data kept
        rd_keep = rd_data;
        en0 = en_cnt;
        do_rd(1'b0, 3'd3, 64'h1000_0000, lat);
        chk("err_range_lat", 512'(lat), 512'd1);
        chk("err_range_err", {511'h0, rd_err}, 512'h1);
        step();
        chk("err_range_noen", 512'(en_cnt - en0), 512'h0);
        chk("err_range_data", rd_data, rd_keep);

        do_rd(1'b1, 3'd3, 64'h8000_0004, lat);
        chk("err_burst_align_lat", 512'(lat), 512'd1);
        chk("err_burst_align_err", {511'h0, rd_err}, 512'h1);
        step();
        chk("err_burst_noen", 512'(en_cnt - en0), 512'h0);
        chk("err_burst_data", rd_data, rd_keep);

        do_rd(1'b0, 3'd4, 64'h8000_0000, lat);
        chk("err_len4", {510'h0, rd_err, lat == 1}, 512'h3);
        step();
        do_rd(1'b0, 3'd2, 64'h8000_0002, lat);
        chk("err_misalign4", {510'h0, rd_err, lat == 1}, 512'h3);
        step();
        do_rd(1'b0, 3'd1, 64'h8000_0002, lat);
        chk("half_aligned_lat", 512'(lat), 512'd3);
        chk("half_aligned_data", rd_data, {448'h0, 64'h1111});
        step();
        do_rd(1'b0, 3'd3, 64'h8080_0000, lat);
        chk("err_top_edge", {510'h0, rd_err, lat == 1}, 512'h3);
        step();
        do_rd(1'b0, 3'd3, 64'h807F_FFF8, lat);
        chk("last_word_ok", {510'h0, rd_err, lat == 3}, 512'h1);
        step();

        // reset during a burst read
        ins_req = 1'b1; ins_burst = 1'b1; ins_addr = 64'h8000_0000;
        t0 = cyc;
        repeat (4) step();
        rst = 1'b1;
        ins_req = 1'b0;
        step();
        chk("midrst_ready", {509'h0, ins_ready, rd_ready, wr_ready}, 512'h0);
        chk("midrst_mem", {510'h0, mem_en, mem_we}, 512'h0);
        chk("midrst_ins_data", ins_data, 512'h0);
        chk("midrst_rd_data", rd_data, 512'h0);
        rst = 1'b0;
        ins_req = 1'b1;
        t0 = cyc;
        wait_rdy(0, 30, lat);
        ins_req = 1'b0;
        for (int k = 0; k < 8; k++) exp_line[64*k +: 64] = 64'h1111 * 64'(k + 1);
        exp_line[128 +: 64] = 64'h0000_0000_FFFF_FFFF;
        chk("reissue_lat", 512'(lat), 512'd10);
        chk("reissue_data", ins_data, exp_line);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
